serial_adder_nbyte: RTL and testbench

Multi-byte sequential adder that wraps the combinational 8-bit adder, `adder_8bit_task`. It accepts two N-byte operands and a carry-in through a start/busy handshake. It feeds the 8-bit adder one byte per cycle, LSB first, and chains the carry through a register. It produces a registered N-byte sum, a carry-out and a one-cycle done pulse. It sits directly upstream of the 8-bit adder, driving its a/b/cin and consuming its {carry,sum}.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_8bit_task.sv | 14 +
 rtl/serial_adder_nbyte.sv | 107 ++++++++++
 tb/tb_serial_adder_nbyte.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the byte-serial adder and its 8-bit slice.
package adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_8bit_task.sv
// Combinational 8-bit adder with carry-in and carry-out.
module adder_8bit_task
  import adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_adder_nbyte.sv
// Multi-byte adder that streams operands through one 8-bit adder, LSB byte
// first, with the inter-byte carry held in a register.
module serial_adder_nbyte
  import adder_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned IdxW = clog2(NBYTES);

  state_e            state_q;
  logic [W-1:0]      a_sh_q;
  logic [W-1:0]      b_sh_q;
  logic [W-1:0]      res_sh_q;
  logic              carry_q;
  logic [IdxW-1:0]   idx_q;
  logic              busy_q;
  logic              done_q;
  logic [W-1:0]      sum_q;
  logic              cout_q;

  logic [BYTE_W-1:0] add_sum;
  logic              add_carry;
  logic [W-1:0]      res_next;

  adder_8bit_task u_adder (
    .a     (a_sh_q[BYTE_W-1:0]),
    .b     (b_sh_q[BYTE_W-1:0]),
    .cin   (carry_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Each new byte enters at the top so after NBYTES steps byte 0 sits at the bottom.
  assign res_next = {add_sum, res_sh_q[W-1:BYTE_W]};

  // FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          a_sh_q   <= a_sh_q >> BYTE_W;
          b_sh_q   <= b_sh_q >> BYTE_W;
          res_sh_q <= res_next;
          carry_q  <= add_carry;
          idx_q    <= idx_q + IdxW'(1);
          if (idx_q == IdxW'(NBYTES - 1)) begin
            sum_q   <= res_next;
            cout_q  <= add_carry;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_nbyte.sv
// Bench for serial_adder_nbyte (NBYTES=4): table vectors with latency checks,
// ignored-start, mid-operation reset and back-to-back held-start sequences.
module tb_serial_adder_nbyte;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc_cnt = 0;
  int done_cyc[$];
  logic [W:0] exp_q[$];
  logic [W:0] hold = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   res;
  } vec_t;

  vec_t vecs[6];

  serial_adder_nbyte #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: compare results on done, and require sum/cout to hold otherwise.
  always @(posedge clk) begin
    logic r;
    r = rst;
    #1;
    cyc_cnt++;
    if (r) begin
      hold = '0;
    end else if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        check("result", {cout, sum}, exp_q.pop_front());
      end
      hold = {cout, sum};
    end else begin
      check("result_stable", {cout, sum}, hold);
    end
  end

  // One operation with per-cycle busy/done timing checks; cycle 1 follows the start edge.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W:0] res);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; cin = vc;
    exp_q.push_back(res);
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("busy_c%0d", k), busy, (k <= 5));
      check($sformatf("done_c%0d", k), done, (k == 5));
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int base;
    int n;
    logic pb;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_678A};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
    vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sum", {cout, sum}, '0);

    for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res);

    // Extra start pulses and operand changes during an operation are ignored.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 100; b = 10; cin = 1'b1;
    exp_q.push_back(33'd111);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 4);
      a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_start_dones", done_cnt - base, 1);
    check("ignored_start_queue", exp_q.size(), 0);

    // Reset during the third ADD cycle aborts without a done pulse.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 32'h5555_5555; b = 32'h1234_0000; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", {cout, sum}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    run_op(200, 100, 1'b1, 33'd301);

    // Start held high: three back-to-back operations.
    base = done_cnt;
    void'(done_cyc.size());
    done_cyc.delete();
    @(negedge clk);
    ra = $urandom; rb = $urandom; rc = $urandom_range(0, 1);
    start = 1'b1; a = ra; b = rb; cin = rc;
    exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    n = 0;
    pb = busy;
    for (int t = 0; t < 40 && done_cnt - base < 3; t++) begin
      @(posedge clk); #2;
      if (busy && !pb) begin
        n++;
        if (n < 3) begin
          ra = $urandom; rb = $urandom; rc = $urandom_range(0, 1);
          a = ra; b = rb; cin = rc;
          exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
        end else begin
          start = 1'b0;
        end
      end
      pb = busy;
    end
    start = 1'b0;
    check("held_dones", done_cnt - base, 3);
    if (done_cyc.size() == 3) begin
      check("held_spacing_1", done_cyc[1] - done_cyc[0], 6);
      check("held_spacing_2", done_cyc[2] - done_cyc[1], 6);
    end
    repeat (4) @(negedge clk);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
